// File: rtl/axis_capture_sink_if.sv
// AXI-Stream bundle: data, valid, ready.
// SLV modport is the sink side.
interface axis #(
  parameter int W = 32
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport SLV (
    input  tdata,
    input  tvalid,
    output tready
  );

  modport MST (
    output tdata,
    output tvalid,
    input  tready
  );
endinterface

// File: rtl/axis_capture_sink.sv
// Always-ready AXI-Stream sink capturing a DEPTH-beat frame.
// Optional keep-every-DECIM-th capture via CAPTURE_DECIM_EN.
module axis_capture_sink #(
  parameter int TWID  = 16,
  parameter     DTYPE = "CX",
  parameter int DEPTH = 128,
  parameter int DECIM = 4,
  localparam int W = (DTYPE == "CX") ? 2 * TWID : TWID,
  localparam int A = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  axis.SLV              s_axis,
  input  logic          arm,
  input  logic          abort,
  input  logic          trig,
  input  logic          rd_en,
  input  logic [A-1:0]  rd_addr,
  output logic [W-1:0]  rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic          done,
  output logic [A:0]    wr_count,
  output logic [31:0]   drop_count
);

  if (DEPTH < 2 || DECIM < 1) begin : g_bad_cfg
    $error("axis_capture_sink: DEPTH>=2, DECIM>=1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAP,
    S_DONE
  } state_t;

  localparam logic [A:0] LAST = (A + 1)'(DEPTH - 1);

  state_t       st;
  state_t       st_nx;
  logic         rdy;
  logic         beat;
  logic         keep;
  logic         we;
  logic         clr;
  logic         inc;
  logic [W-1:0] mem [DEPTH];

  assign s_axis.tready = rdy;
  assign beat = s_axis.tvalid && rdy;
  assign busy = (st == S_ARMED) || (st == S_CAP);
  assign done = (st == S_DONE);

`ifdef CAPTURE_DECIM_EN
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PW-1:0] PLAST = PW'(DECIM - 1);
  localparam logic [PW-1:0] PONE  =
    (DECIM > 1) ? PW'(1) : '0;

  logic [PW-1:0] ph;

  assign keep = (ph == '0);

  // Phase of the next beat; trigger beat is phase 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= '0;
    end else if (st == S_ARMED && st_nx == S_CAP) begin
      ph <= PONE;
    end else if (st == S_CAP && beat) begin
      ph <= (ph == PLAST) ? '0 : ph + PW'(1);
    end
  end
`else
  assign keep = 1'b1;
`endif

  // Next state plus write/clear/drop strobes
  always_comb begin
    st_nx = st;
    we    = 1'b0;
    clr   = 1'b0;
    inc   = 1'b0;
    if (abort) begin
      st_nx = S_IDLE;
      inc   = beat;
    end else begin
      unique case (st)
        S_IDLE, S_DONE: begin
          inc = beat;
          if (arm) begin
            st_nx = S_ARMED;
            clr   = 1'b1;
          end
        end
        S_ARMED: begin
          if (beat && trig) begin
            we    = 1'b1;
            st_nx = S_CAP;
          end else begin
            inc = beat;
          end
        end
        S_CAP: begin
          if (beat && keep) begin
            we = 1'b1;
            if (wr_count == LAST) st_nx = S_DONE;
          end
        end
        default: st_nx = S_IDLE;
      endcase
    end
  end

  // State, ready and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= S_IDLE;
      rdy        <= 1'b0;
      wr_count   <= '0;
      drop_count <= '0;
    end else begin
      st  <= st_nx;
      rdy <= 1'b1;
      if (clr) begin
        wr_count <= '0;
      end else if (we) begin
        wr_count <= wr_count + 1'b1;
      end
      if (inc && drop_count != '1) begin
        drop_count <= drop_count + 32'd1;
      end
    end
  end

  // Capture buffer write; contents survive reset
  always_ff @(posedge clk) begin
    if (we) mem[wr_count[A-1:0]] <= s_axis.tdata;
  end

  // Registered read port; old data on same-cycle write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end

endmodule
